// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, slave FSM state encodings
// and a constant-evaluable clog2 helper for sizing index fields.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    W_IDLE      = 2'd0,
    W_HAVE_ADDR = 2'd1,
    W_HAVE_DATA = 2'd2,
    W_RESP      = 2'd3
  } wr_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_e;

  // Ceiling log2; returns 0 for v <= 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned p;
    r = 0;
    p = 1;
    while (p < v) begin
      p = p << 1;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/axi_lite_reg_bank.sv
// Register bank: NUM_REGS words with a byte-enabled write port and an
// asynchronous read port.
// Ports: aclk/aresetn; we/widx/wdata/wstrb write port; ridx -> rd_data_c
// combinational read; reg_flat exposes all registers, reg i at
// [i*DATA_WIDTH +: DATA_WIDTH].
module axi_lite_reg_bank
  import axi_lite_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REGS   = 8,
  localparam int unsigned IDX_W     = clog2(NUM_REGS),
  localparam int unsigned STRB_W    = DATA_WIDTH / 8
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  input  logic                           we,
  input  logic [IDX_W-1:0]               widx,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic [STRB_W-1:0]              wstrb,
  input  logic [IDX_W-1:0]               ridx,
  output logic [DATA_WIDTH-1:0]          rd_data_c,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_flat
);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

  // Byte-lane merge of the write into the addressed word.
  always_comb begin
    regs_d = regs_q;
    if (we) begin
      for (int unsigned b = 0; b < STRB_W; b++) begin
        if (wstrb[b]) begin
          regs_d[widx][b*8 +: 8] = wdata[b*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Read sees the pre-write value when a write lands on the same edge.
  assign rd_data_c = regs_q[ridx];

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
    assign reg_flat[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
  end

endmodule

// File: rtl/axi_lite_slave_regs.sv
// AXI4-Lite slave register bank with independent write and read FSMs,
// one outstanding transaction per channel.
// Ports: aclk/aresetn; AW/W/B write channels; AR/R read channels;
// reg_out presents all registers flat; reg_wr_pulse pulses one cycle
// after an in-range write commit to the addressed register.
module axi_lite_slave_regs
  import axi_lite_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REGS   = 8
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  input  logic [ADDR_WIDTH-1:0]          awaddr,
  input  logic                           awvalid,
  output logic                           awready,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic [DATA_WIDTH/8-1:0]        wstrb,
  input  logic                           wvalid,
  output logic                           wready,
  output logic [1:0]                     bresp,
  output logic                           bvalid,
  input  logic                           bready,
  input  logic [ADDR_WIDTH-1:0]          araddr,
  input  logic                           arvalid,
  output logic                           arready,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic [1:0]                     rresp,
  output logic                           rvalid,
  input  logic                           rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  output logic [NUM_REGS-1:0]            reg_wr_pulse
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned IDX_W  = clog2(NUM_REGS);
  localparam int unsigned OFFS_W = clog2(STRB_W);

  // ---------------- write path ----------------
  wr_state_e             wr_state_q, wr_state_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]     wstrb_q, wstrb_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  bvalid_q, bvalid_d;
  logic                  awready_q, awready_d;
  logic                  wready_q, wready_d;
  logic [NUM_REGS-1:0]   pulse_q, pulse_d;

  logic                  aw_hs_c, w_hs_c, commit_c;
  logic [ADDR_WIDTH-1:0] c_addr_c, c_word_c;
  logic [DATA_WIDTH-1:0] c_data_c;
  logic [STRB_W-1:0]     c_strb_c;
  logic                  c_in_range_c;
  logic [IDX_W-1:0]      c_idx_c;

  assign aw_hs_c = awvalid & awready_q;
  assign w_hs_c  = wvalid & wready_q;

  // Commit operands: take the held half, or the live bus if not yet held.
  assign c_addr_c     = (wr_state_q == W_HAVE_ADDR) ? awaddr_q : awaddr;
  assign c_data_c     = (wr_state_q == W_HAVE_DATA) ? wdata_q  : wdata;
  assign c_strb_c     = (wr_state_q == W_HAVE_DATA) ? wstrb_q  : wstrb;
  assign c_word_c     = ADDR_WIDTH'(c_addr_c >> OFFS_W);
  assign c_in_range_c = (c_word_c < ADDR_WIDTH'(NUM_REGS));
  assign c_idx_c      = c_word_c[IDX_W-1:0];

  // Write FSM next-state and registered outputs.
  always_comb begin
    wr_state_d = wr_state_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bresp_d    = bresp_q;
    pulse_d    = '0;
    commit_c   = 1'b0;

    case (wr_state_q)
      W_IDLE: begin
        if (aw_hs_c && w_hs_c) begin
          commit_c   = 1'b1;
          wr_state_d = W_RESP;
        end else if (aw_hs_c) begin
          awaddr_d   = awaddr;
          wr_state_d = W_HAVE_ADDR;
        end else if (w_hs_c) begin
          wdata_d    = wdata;
          wstrb_d    = wstrb;
          wr_state_d = W_HAVE_DATA;
        end
      end
      W_HAVE_ADDR: begin
        if (w_hs_c) begin
          commit_c   = 1'b1;
          wr_state_d = W_RESP;
        end
      end
      W_HAVE_DATA: begin
        if (aw_hs_c) begin
          commit_c   = 1'b1;
          wr_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (bready) begin
          wr_state_d = W_IDLE;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase

    if (commit_c) begin
      bresp_d = c_in_range_c ? RESP_OKAY : RESP_SLVERR;
      if (c_in_range_c) begin
        pulse_d = NUM_REGS'(1) << c_idx_c;
      end
    end

    awready_d = (wr_state_d == W_IDLE) || (wr_state_d == W_HAVE_DATA);
    wready_d  = (wr_state_d == W_IDLE) || (wr_state_d == W_HAVE_ADDR);
    bvalid_d  = (wr_state_d == W_RESP);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_state_q <= W_IDLE;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bresp_q    <= RESP_OKAY;
      bvalid_q   <= 1'b0;
      awready_q  <= 1'b1;
      wready_q   <= 1'b1;
      pulse_q    <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bresp_q    <= bresp_d;
      bvalid_q   <= bvalid_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      pulse_q    <= pulse_d;
    end
  end

  // ---------------- read path ----------------
  rd_state_e             rd_state_q, rd_state_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic                  rvalid_q, rvalid_d;
  logic                  arready_q, arready_d;

  logic                  ar_hs_c;
  logic [ADDR_WIDTH-1:0] r_word_c;
  logic                  r_in_range_c;
  logic [DATA_WIDTH-1:0] bank_rd_c;

  assign ar_hs_c      = arvalid & arready_q;
  assign r_word_c     = ADDR_WIDTH'(araddr >> OFFS_W);
  assign r_in_range_c = (r_word_c < ADDR_WIDTH'(NUM_REGS));

  // Read FSM next-state and registered outputs.
  always_comb begin
    rd_state_d = rd_state_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;

    case (rd_state_q)
      R_IDLE: begin
        if (ar_hs_c) begin
          rdata_d    = r_in_range_c ? bank_rd_c : '0;
          rresp_d    = r_in_range_c ? RESP_OKAY : RESP_SLVERR;
          rd_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (rready) begin
          rd_state_d = R_IDLE;
        end
      end
      default: rd_state_d = R_IDLE;
    endcase

    arready_d = (rd_state_d == R_IDLE);
    rvalid_d  = (rd_state_d == R_DATA);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_state_q <= R_IDLE;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
      rvalid_q   <= 1'b0;
      arready_q  <= 1'b1;
    end else begin
      rd_state_q <= rd_state_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      rvalid_q   <= rvalid_d;
      arready_q  <= arready_d;
    end
  end

  // ---------------- storage ----------------
  axi_lite_reg_bank #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS)
  ) u_bank (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .we        (commit_c & c_in_range_c),
    .widx      (c_idx_c),
    .wdata     (c_data_c),
    .wstrb     (c_strb_c),
    .ridx      (r_word_c[IDX_W-1:0]),
    .rd_data_c (bank_rd_c),
    .reg_flat  (reg_out)
  );

  assign awready      = awready_q;
  assign wready       = wready_q;
  assign bresp        = bresp_q;
  assign bvalid       = bvalid_q;
  assign arready      = arready_q;
  assign rdata        = rdata_q;
  assign rresp        = rresp_q;
  assign rvalid       = rvalid_q;
  assign reg_wr_pulse = pulse_q;

endmodule
